// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and default widths for the SPI register controller.
// Holds the FSM state enum and the frame-length constant.
package spi_reg_ctrl_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int REG_W_DEF  = 8;
  localparam int ACK_TO_DEF = 15;
  localparam int FRAME_LEN  = 1 + ADDR_W_DEF + REG_W_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RD_REQ,
    S_DATA,
    S_WR_REQ,
    S_WAIT_CS
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, W bits wide, async active-high reset.
// Ports: clk, rst, i_d (async in), o_q (synchronized out).
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_m;
  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m <= RST_VAL;
      r_q <= RST_VAL;
    end else begin
      r_m <= i_d;
      r_q <= r_m;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave that turns 1+ADDR_W+REG_W bit frames into
// register-bank read/write requests with ack/err/timeout handling.
// Ports: clk, rst, ena; SPI pins spi_sclk/spi_cs_n/spi_mosi/spi_miso;
// bank side wr_rdn, addr, wdata, we, rdata, ack, err; status_err.
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              wr_rdn,
  output logic [ADDR_W-1:0] addr,
  output logic [REG_W-1:0]  wdata,
  output logic              we,
  input  logic [REG_W-1:0]  rdata,
  input  logic              ack,
  input  logic              err,
  output logic              status_err
);

  localparam int FL = 1 + ADDR_W + REG_W;
  localparam int CW = $clog2(FL + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  // {sclk, cs_n, mosi}
  logic [2:0] w_s2;
  logic [1:0] r_s3;

  sync_2ff #(.W(3), .RST_VAL(3'b010)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({spi_sclk, spi_cs_n, spi_mosi}),
    .o_q (w_s2)
  );

  logic w_rise, w_fall, w_cs_fall, w_cs_hi, w_mosi;

  assign w_rise    = w_s2[2] & ~r_s3[1];
  assign w_fall    = ~w_s2[2] & r_s3[1];
  assign w_cs_fall = ~w_s2[1] & r_s3[0];
  assign w_cs_hi   = w_s2[1];
  assign w_mosi    = w_s2[0];

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_cmd;
  logic [REG_W-2:0]  r_rx;
  logic [REG_W-1:0]  r_tx;
  logic [TW-1:0]     r_tmo;
  logic              r_late;
  logic              r_wr_rdn;
  logic [ADDR_W-1:0] r_addr;
  logic [REG_W-1:0]  r_wdata;
  logic              r_we;
  logic              r_miso;
  logic              r_err;

  logic [ADDR_W:0]   w_cmd_nxt;
  logic [REG_W-1:0]  w_rx_nxt;
  logic [CW-1:0]     w_cnt_rd;
  logic              w_late;
  logic              w_done;
  logic              w_tmo_hit;

  assign w_cmd_nxt = {r_cmd, w_mosi};
  assign w_rx_nxt  = {r_rx, w_mosi};
  assign w_tmo_hit = (r_tmo == TW'(ACK_TIMEOUT - 1));
  assign w_done    = ack | err | w_tmo_hit;
  // A data-phase falling edge seen before completion makes the read late
  assign w_late    = r_late | w_fall;
  // Data-bit rises keep counting while the read is still outstanding
  assign w_cnt_rd  = (w_rise && r_cnt != CW'(REG_W)) ?
                     r_cnt + CW'(1) : r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s3     <= 2'b01;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_cmd    <= '0;
      r_rx     <= '0;
      r_tx     <= '0;
      r_tmo    <= '0;
      r_late   <= 1'b0;
      r_wr_rdn <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_miso   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_s3 <= w_s2[2:1];
      if (!ena) begin
        r_state <= S_IDLE;
        r_we    <= 1'b0;
        r_miso  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_miso <= 1'b0;
            if (w_cs_fall) begin
              r_state <= S_CMD;
              r_cnt   <= '0;
              r_late  <= 1'b0;
              r_tx    <= '0;
            end
          end
          S_CMD: begin
            if (w_cs_hi) begin
              r_state <= S_IDLE;
            end else if (w_rise) begin
              r_cmd <= w_cmd_nxt[ADDR_W-1:0];
              if (r_cnt == CW'(ADDR_W)) begin
                r_cnt    <= '0;
                r_tmo    <= '0;
                r_addr   <= w_cmd_nxt[ADDR_W-1:0];
                r_wr_rdn <= w_cmd_nxt[ADDR_W];
                if (w_cmd_nxt[ADDR_W]) begin
                  r_state <= S_DATA;
                end else begin
                  r_state <= S_RD_REQ;
                  r_we    <= 1'b1;
                end
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end
          S_RD_REQ: begin
            r_cnt <= w_cnt_rd;
            if (w_fall) begin
              r_late <= 1'b1;
              r_err  <= 1'b1;
            end
            if (w_done) begin
              r_we <= 1'b0;
              r_tx <= (ack && !w_late) ? rdata : '0;
              if (!ack) begin
                r_err <= 1'b1;
              end else if (!w_late && (&r_addr)) begin
                r_err <= 1'b0;
              end
              r_state <= (w_cnt_rd == CW'(REG_W)) ?
                         S_WAIT_CS : S_DATA;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          S_DATA: begin
            if (w_cs_hi) begin
              r_state <= S_IDLE;
              r_miso  <= 1'b0;
            end else begin
              if (w_fall) begin
                r_miso <= r_tx[REG_W-1];
                r_tx   <= {r_tx[REG_W-2:0], 1'b0};
              end
              if (w_rise) begin
                r_rx <= w_rx_nxt[REG_W-2:0];
                if (r_cnt == CW'(REG_W - 1)) begin
                  r_cnt  <= '0;
                  r_miso <= 1'b0;
                  if (r_wr_rdn) begin
                    r_state <= S_WR_REQ;
                    r_we    <= 1'b1;
                    r_wdata <= w_rx_nxt;
                    r_tmo   <= '0;
                  end else begin
                    r_state <= S_WAIT_CS;
                  end
                end else begin
                  r_cnt <= r_cnt + CW'(1);
                end
              end
            end
          end
          S_WR_REQ: begin
            if (w_done) begin
              r_we    <= 1'b0;
              r_state <= S_WAIT_CS;
              if (!ack) r_err <= 1'b1;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          S_WAIT_CS: begin
            r_miso <= 1'b0;
            if (w_cs_hi) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign spi_miso   = r_miso;
  assign wr_rdn     = r_wr_rdn;
  assign addr       = r_addr;
  assign wdata      = r_wdata;
  assign we         = r_we;
  assign status_err = r_err;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed + randomized bench for spi_reg_ctrl with a register-bank
// responder and a behavioural model of bank contents and status_err.
module tb_spi_reg_ctrl;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       spi_miso;
  logic       wr_rdn;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic [7:0] rdata;
  logic       ack;
  logic       err;
  logic       status_err;

  spi_reg_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .spi_sclk   (sclk),
    .spi_cs_n   (cs_n),
    .spi_mosi   (mosi),
    .spi_miso   (spi_miso),
    .wr_rdn     (wr_rdn),
    .addr       (addr),
    .wdata      (wdata),
    .we         (we),
    .rdata      (rdata),
    .ack        (ack),
    .err        (err),
    .status_err (status_err)
  );

  always #5 clk = ~clk;

  // bank_mode: 0 = never respond, 1 = ack, 2 = err
  int         bank_mode = 1;
  int         bank_dly  = 0;
  bit         force_en  = 1'b0;
  logic [7:0] force_val = 8'h00;

  logic [7:0] bank_mem [128];
  int         n_req = 0;
  int         we_cycles = 0;
  int         viol = 0;
  int         wait_cnt = 0;
  bit         active = 1'b0;
  bit         acked = 1'b0;
  logic       rec_wr;
  logic [6:0] rec_addr;
  logic [7:0] rec_wdata;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 11);
  endfunction

  always @(negedge clk) begin
    ack   = 1'b0;
    err   = 1'b0;
    rdata = 8'($urandom);
    if (rst) begin
      for (int i = 0; i < 128; i++) bank_mem[i] = init_val(i);
      active = 1'b0;
      acked  = 1'b0;
    end else if (we) begin
      if (acked) viol++;
      if (!active) begin
        active    = 1'b1;
        wait_cnt  = 0;
        we_cycles = 0;
        n_req++;
        rec_wr    = wr_rdn;
        rec_addr  = addr;
        rec_wdata = wdata;
      end
      we_cycles++;
      if (!acked && bank_mode != 0 && wait_cnt == bank_dly) begin
        if (bank_mode == 2) begin
          err = 1'b1;
        end else begin
          ack   = 1'b1;
          rdata = force_en ? force_val : bank_mem[addr];
          if (wr_rdn) bank_mem[addr] = wdata;
        end
        acked = 1'b1;
      end
      wait_cnt++;
    end else begin
      active = 1'b0;
      acked  = 1'b0;
    end
  end

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_mem [128];
  logic       exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic spi_frame(input logic [15:0] f, input int nbits,
                           input bit raise, output logic [7:0] mb);
    mb = 8'h00;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = f[15-i];
      repeat (HALF) @(negedge clk);
      if (i >= 8) mb = {mb[6:0], spi_miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    if (raise) begin
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (40) @(negedge clk);
    end
  endtask

  task automatic do_txn(input string tag, input bit wr,
                        input logic [6:0] a, input logic [7:0] d,
                        input int mode, input int dly, input bit late);
    int         n0;
    logic [7:0] mb;
    logic [7:0] exp_m;
    bit         ok;
    bank_mode = mode;
    bank_dly  = dly;
    n0 = n_req;
    spi_frame({wr, a, wr ? d : 8'h00}, 16, 1'b1, mb);
    ok = (mode == 1) && !late;
    chk({tag, "_nreq"}, n_req - n0, 1);
    chk({tag, "_wr"}, 32'(rec_wr), 32'(wr));
    chk({tag, "_addr"}, 32'(rec_addr), 32'(a));
    if (wr) begin
      chk({tag, "_wdata"}, 32'(rec_wdata), 32'(d));
      if (mode == 1) exp_mem[a] = d;
    end else begin
      exp_m = ok ? (force_en ? force_val : exp_mem[a]) : 8'h00;
      chk({tag, "_miso"}, 32'(mb), 32'(exp_m));
    end
    if (mode != 1 || (!wr && late)) exp_err = 1'b1;
    else if (!wr && a == 7'h7F) exp_err = 1'b0;
    chk({tag, "_serr"}, 32'(status_err), 32'(exp_err));
    chk({tag, "_we_hold"}, viol, 0);
    chk({tag, "_we_len"}, we_cycles, (mode == 0) ? 15 : dly + 1);
    chk({tag, "_we_idle"}, 32'(we), 0);
  endtask

  initial begin
    logic [7:0] mb;
    int         n0;
    bit         w;
    int         md;
    for (int i = 0; i < 128; i++) exp_mem[i] = init_val(i);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    chk("rst_we", 32'(we), 0);
    chk("rst_wr_rdn", 32'(wr_rdn), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_miso", 32'(spi_miso), 0);
    chk("rst_serr", 32'(status_err), 0);

    do_txn("wr_a5", 1'b1, 7'h0A, 8'hA5, 1, 2, 1'b0);

    force_en  = 1'b1;
    force_val = 8'h3C;
    do_txn("rd_3c", 1'b0, 7'h0A, 8'h00, 1, 2, 1'b0);
    force_en  = 1'b0;

    do_txn("wr_tmo", 1'b1, 7'h33, 8'h77, 0, 0, 1'b0);

    n0 = n_req;
    bank_mode = 1;
    spi_frame(16'h8AA5, 5, 1'b1, mb);
    chk("abort_nreq", n_req - n0, 0);
    chk("abort_we", 32'(we), 0);
    do_txn("post_abort", 1'b1, 7'h05, 8'h11, 1, 1, 1'b0);

    do_txn("rd_late", 1'b0, 7'h0A, 8'h00, 1, 10, 1'b1);
    do_txn("rd_7f", 1'b0, 7'h7F, 8'h00, 1, 1, 1'b0);

    ena = 1'b0;
    n0 = n_req;
    spi_frame(16'h8155, 16, 1'b1, mb);
    chk("ena_off_nreq", n_req - n0, 0);
    ena = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 14; k++) begin
      w  = 1'($urandom_range(0, 1));
      md = ($urandom_range(0, 5) == 0) ? 2 : 1;
      do_txn("rnd", w, 7'($urandom_range(0, 127)), 8'($urandom),
             md, $urandom_range(0, 4), 1'b0);
    end
    do_txn("rnd_rd_back", 1'b0, 7'h05, 8'h00, 1, 3, 1'b0);

    bank_mode = 0;
    spi_frame(16'hC4E7, 16, 1'b0, mb);
    @(negedge clk);
    chk("pre_rst_we", 32'(we), 1);
    rst = 1'b1;
    #1;
    chk("arst_we", 32'(we), 0);
    chk("arst_wr_rdn", 32'(wr_rdn), 0);
    chk("arst_addr", 32'(addr), 0);
    chk("arst_wdata", 32'(wdata), 0);
    chk("arst_miso", 32'(spi_miso), 0);
    chk("arst_serr", 32'(status_err), 0);
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_we", 32'(we), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7, register address width.
REQ-002 Parameter REG_W, default 8, register data width.
REQ-003 Parameter ACK_TIMEOUT, default 15, maximum clk cycles from request to ack/err.
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock; f_clk SHALL be >= 16 x f_sclk.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 ena  input  1  block enable; when low, the FSM holds IDLE and ignores the SPI pins.
REQ-008 spi_sclk, spi_cs_n, spi_mosi  input  1 each  asynchronous SPI mode-0 pins.
REQ-009 spi_miso  output  1  serial read data.
REQ-010 wr_rdn  output  1  request type: 1 = write, 0 = read.
REQ-011 addr  output  ADDR_W  register address.
REQ-012 wdata  output  REG_W  write data.
REQ-013 we  output  1  request strobe, held until ack, err or timeout.
REQ-014 rdata  input  REG_W  read data, valid in the ack cycle.
REQ-015 ack / err  input  1 each  single-cycle completion / error response from the register bank.
REQ-016 status_err  output  1  sticky error flag.

Function
REQ-017 spi_sclk, spi_cs_n and spi_mosi SHALL each pass a 2-flop synchronizer; edges are detected from the 2nd and 3rd stages.
REQ-018 Frame format (MSB first) SHALL be: 1 bit wr_rdn, then ADDR_W address bits, then REG_W data bits, for a total of 1+ADDR_W+REG_W bits (16 by default).
REQ-019 MOSI SHALL be sampled on a detected sclk rising edge; spi_miso SHALL update on a detected falling edge.
REQ-020 FSM states SHALL be IDLE, CMD, RD_REQ, DATA, WR_REQ, WAIT_CS.
REQ-021 IDLE -> CMD on a synchronized cs_n falling edge; the bit counter clears.
REQ-022 CMD -> RD_REQ after bit 1+ADDR_W if wr_rdn=0; CMD -> DATA if wr_rdn=1.
REQ-023 RD_REQ behaviour:
- assert we, wr_rdn=0 and addr the cycle after the last address bit;
- on ack, load rdata into the TX shifter and go to DATA;
- on err or timeout, set status_err, load all-zeros and go to DATA.
REQ-024 If the first data-phase falling edge arrives before read completion, spi_miso SHALL drive 0 for the frame and status_err SHALL be set.
REQ-025 DATA -> WR_REQ after REG_W bits on a write; DATA -> WAIT_CS after REG_W bits on a read.
REQ-026 WR_REQ SHALL assert we, wr_rdn=1, addr and wdata until ack/err/timeout; status_err sets on err or timeout; then go to WAIT_CS.
REQ-027 WAIT_CS -> IDLE on cs_n high.
REQ-028 Extra sclk edges in WAIT_CS SHALL be ignored.
REQ-029 A cs_n rising edge in CMD or DATA SHALL abort the frame: no request is issued and the FSM returns to IDLE.
REQ-030 A cs_n rising edge during RD_REQ or WR_REQ SHALL let the pending request complete; the FSM then returns to IDLE.
REQ-031 we SHALL drop in the same cycle that ack or err is sampled.
REQ-032 Only one request SHALL be in flight at any time.
REQ-033 The timeout counter SHALL saturate and SHALL NOT wrap.
REQ-034 spi_miso SHALL be 0 whenever cs_n is high or the FSM is not in DATA.
REQ-035 status_err SHALL clear only on reset, or on a successful read frame to address all-ones.

Reset
REQ-036 On rst: FSM=IDLE; we=0, wr_rdn=0, addr=0, wdata=0, spi_miso=0, status_err=0.
REQ-037 On rst: all counters and shifters SHALL be 0; synchronizers SHALL reset to sclk=0, cs_n=1, mosi=0.
REQ-038 Reset asserted mid-frame SHALL abort the frame immediately, including any pending request.

Structure
REQ-039 A shared package SHALL hold the FSM state enum, the default widths and the frame-length constant.
REQ-040 A single sub-module, sync_2ff (parameterised width), SHALL implement the synchronizers.

Verification
REQ-041 Write 0x0A <- 0xA5 (frame 0x8AA5) -> one we pulse train with wr_rdn=1, addr=0x0A, wdata=0xA5; we drops on ack.
REQ-042 Read 0x0A with rdata=0x3C, ack 2 cycles after we -> MISO bits = 0x3C; status_err=0.
REQ-043 Write frame; bank never acks -> we deasserts after 15 cycles; status_err=1.
REQ-044 cs_n raised after 5 bits -> no we; FSM IDLE; the next full frame completes correctly.
REQ-045 Read with ack delayed beyond the first data falling edge -> MISO=0x00; status_err=1; a read of 0x7F then clears status_err.
REQ-046 rst asserted during WR_REQ -> we=0 within 0 cycles (async); all outputs at reset values.
